// File: rtl/micro_ctrl_pkg.sv
// Shared types and constants for the micro_ctrl UART loader/sequencer.
package micro_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_CNT,
        LD_HI,
        LD_LO,
        CPU_RST,
        RUN,
        HALTED
    } mc_state_t;

    localparam logic [7:0] CMD_LOAD   = 8'hA5;
    localparam logic [7:0] CMD_RUN    = 8'h52;
    localparam logic [7:0] CMD_PAUSE  = 8'h50;
    localparam logic [7:0] CMD_STEP   = 8'h53;
    localparam logic [7:0] CMD_RSTCPU = 8'h5A;

    // Word count register must hold 256 (count byte 0)
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned BYTE_W = 8;

    // Counter width for a divide-by-div counter, never below one bit
    function automatic int unsigned div_cnt_w(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/micro_ctrl_pc_en_gen.sv
// PCenable divider: counts 0..EN_DIV-1 while enabled and flags the cycle
// before the count reaches EN_DIV-1, so the registered pulse lands on it.
module pc_en_gen
    import micro_ctrl_pkg::*;
#(
    parameter int unsigned EN_DIV = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic pulse_c
);

    localparam int unsigned CW = div_cnt_w(EN_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CW'(EN_DIV - 1)) ? '0 : cnt + CW'(1);
        end
    end

    assign pulse_c = enable && (cnt == CW'(EN_DIV - 2));

endmodule

// File: rtl/micro_ctrl.sv
// UART byte-stream loader and run/pause/step/halt sequencer for the micro core.
module micro_ctrl
    import micro_ctrl_pkg::*;
#(
    parameter int unsigned       WIDTH          = 16,
    parameter int unsigned       IRAM_ADDR_BITS = 8,
    parameter int unsigned       EN_DIV         = 3,
    parameter logic [WIDTH-1:0]  HALT_INSTR     = 16'hC000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BYTE_W-1:0]         rx_data,
    input  logic                      rx_valid,
    input  logic [WIDTH-1:0]          monInstr,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      cpu_reset,
    output logic                      PCenable,
    output logic                      running,
    output logic                      halted,
    output logic                      loading
);

    mc_state_t                 state, state_nxt;
    logic [IRAM_ADDR_BITS-1:0] addr, addr_nxt;
    logic [CNT_W-1:0]          remain, remain_nxt;
    logic [BYTE_W-1:0]         hi_byte, hi_nxt;
    logic                      rst_phase, rst_phase_nxt;
    logic [IRAM_ADDR_BITS-1:0] wa_nxt;
    logic [WIDTH-1:0]          din_nxt;
    logic                      wen_nxt;
    logic                      pc_nxt;
    logic                      div_pulse_c;
    logic                      halt_c;

    assign halt_c = (monInstr == HALT_INSTR);

    pc_en_gen #(
        .EN_DIV (EN_DIV)
    ) u_pc_en_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .pulse_c (div_pulse_c)
    );

    // State and registered outputs; outputs follow the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remain    <= '0;
            hi_byte   <= '0;
            rst_phase <= 1'b0;
            iram_wa   <= '0;
            iram_din  <= '0;
            iram_wen  <= 1'b0;
            cpu_reset <= 1'b0;
            PCenable  <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            loading   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remain    <= remain_nxt;
            hi_byte   <= hi_nxt;
            rst_phase <= rst_phase_nxt;
            iram_wa   <= wa_nxt;
            iram_din  <= din_nxt;
            iram_wen  <= wen_nxt;
            cpu_reset <= (state_nxt == CPU_RST);
            PCenable  <= pc_nxt;
            running   <= (state_nxt == RUN);
            halted    <= (state_nxt == HALTED);
            loading   <= (state_nxt == LD_CNT) || (state_nxt == LD_HI) ||
                         (state_nxt == LD_LO);
        end
    end

    // Next-state, byte assembly and output decisions
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remain_nxt    = remain;
        hi_nxt        = hi_byte;
        rst_phase_nxt = 1'b0;
        wa_nxt        = iram_wa;
        din_nxt       = iram_din;
        wen_nxt       = 1'b0;
        pc_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD:   state_nxt = LD_CNT;
                        CMD_RUN:    state_nxt = RUN;
                        CMD_STEP:   pc_nxt    = 1'b1;
                        CMD_RSTCPU: state_nxt = CPU_RST;
                        default:    ;
                    endcase
                end
            end
            LD_CNT: begin
                if (rx_valid) begin
                    remain_nxt = (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
                    addr_nxt   = '0;
                    state_nxt  = LD_HI;
                end
            end
            LD_HI: begin
                if (rx_valid) begin
                    hi_nxt    = rx_data;
                    state_nxt = LD_LO;
                end
            end
            LD_LO: begin
                if (rx_valid) begin
                    wen_nxt    = 1'b1;
                    wa_nxt     = addr;
                    din_nxt    = WIDTH'({hi_byte, rx_data});
                    addr_nxt   = addr + IRAM_ADDR_BITS'(1);
                    remain_nxt = remain - CNT_W'(1);
                    state_nxt  = (remain == CNT_W'(1)) ? CPU_RST : LD_HI;
                end
            end
            CPU_RST: begin
                rst_phase_nxt = 1'b1;
                if (rst_phase) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                // Accepted commands win over halt so no command byte is lost
                if (rx_valid && (rx_data == CMD_LOAD)) begin
                    state_nxt = LD_CNT;
                end else if (rx_valid && (rx_data == CMD_PAUSE)) begin
                    state_nxt = IDLE;
                end else if (rx_valid && (rx_data == CMD_RSTCPU)) begin
                    state_nxt = CPU_RST;
                end else if (halt_c) begin
                    state_nxt = HALTED;
                end else begin
                    pc_nxt = div_pulse_c;
                end
            end
            HALTED: begin
                if (rx_valid && (rx_data == CMD_LOAD)) begin
                    state_nxt = LD_CNT;
                end else if (rx_valid && (rx_data == CMD_RSTCPU)) begin
                    state_nxt = CPU_RST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
